sync_counter: RTL and testbench
===============================

// Module: sync_counter
//
// PURPOSE
//   Parameterised binary up-counter with count enable and synchronous reset.
//   Generic building block for timers, address generators and event counting.
//   Wraps silently modulo 2**WIDTH.
//   Flags the terminal count so that counters can be cascaded.
//
// PARAMETERS
//   WIDTH    default 3    counter width in bits; legal range 1..32
//
// PORTS
//   clk      input   1      rising-edge clock; the only clock
//   reset    input   1      synchronous, active-high reset
//   enable   input   1      count enable; 1 = increment on the next clk rising edge
//   count    output  WIDTH  current count value, registered
//   tc       output  1      terminal count: high when count == 2**WIDTH-1 and enable == 1
//
// BEHAVIOUR
//   - Single clock domain. All state changes occur on the rising edge of clk only.
//   - Synchronous reset:
//     - reset is sampled only at the rising edge of clk.
//     - reset == 1 at an edge forces count to 0 on that edge.
//     - reset has priority over enable.
//   - Initial value: count is 0 at time zero, so operation without any reset
//     pulse is defined. The initial value is 0 with or without reset applied.
//   - Counting:
//     - reset == 0 and enable == 1 at an edge: count <= count + 1.
//     - reset == 0 and enable == 0 at an edge: count holds its value.
//   - Latency: count changes exactly one clock edge after the enable or reset
//     condition is sampled. There is no combinational path from inputs to count.
//   - Wrap-around: 2**WIDTH-1 + 1 -> 0. There is no saturation and no sticky
//     overflow flag.
//   - tc:
//     - Combinational: (count == {WIDTH{1'b1}}) & enable.
//     - When high, the next enabled edge wraps count to 0.
//     - tc is forced low while reset == 1.
//   - Reset mid-count: takes effect on the first edge on which it is sampled high.
//     Counting resumes from 0 on the first edge with reset == 0 and enable == 1.
//   - Simultaneous reset == 1 and enable == 1: count becomes 0. No increment occurs.
//   - Enable toggling between edges has no effect. Only the sampled value matters.
//   - No X propagation from count after time zero.
//     An X on enable with reset == 0 is not required to be handled.
//
// TESTING  (WIDTH=3, clk period 10, first rising edge at t=5)
//   1. reset=0, enable=1 for 3 edges (t<30) -> count 0,1,2,3; count == 3 at t=30.
//   2. enable=0 for 3 edges (t=30..60) -> count holds 3; tc stays 0.
//   3. enable=1 for 7 edges (t=60..130) -> count 4,5,6,7,0,1,2.
//      tc is high while count == 7; count wraps to 0; count == 2 at t=130.
//   4. reset=1 for one edge (t=130..140) with enable=1 -> count == 0 after edge t=135.
//   5. reset=0, enable=1 for 3 edges (t=140..170) -> count 1,2,3.
//   6. With count == 5, assert reset and enable together -> count == 0 next edge, not 6.

Source files
------------

// File: rtl/sync_counter_if.sv
// ----------------------------------------------------------------------------
// sync_counter_if : count-enable / count / terminal-count bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sync_counter_if #(
  parameter int WIDTH = 3
);
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output enable,
    input  count,
    input  tc
  );

  modport slave (
    input  enable,
    output count,
    output tc
  );
endinterface

`default_nettype wire

// File: rtl/sync_counter.sv
// ----------------------------------------------------------------------------
// sync_counter : WIDTH-bit wrapping up-counter with enable, sync reset, tc
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_counter #(
  parameter int WIDTH = 3
) (
  input  wire logic      clk,
  input  wire logic      reset,
  sync_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Declaration initialiser gives a defined zero before any reset pulse.
  logic [WIDTH-1:0] r_count = '0;
  logic [WIDTH-1:0] w_count_inc;
  logic             w_at_max;

  assign w_count_inc = r_count + c_ONE;
  assign w_at_max    = (r_count == c_ALL_ONES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (bus.enable) begin
      r_count <= w_count_inc;
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = w_at_max & bus.enable & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_sync_counter.sv
// ----------------------------------------------------------------------------
// tb_sync_counter : directed vectors, queued expectations, decoupled monitor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sync_counter;

  localparam int WIDTH = 3;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             tc;
    int               idx;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;
  exp_t sb_q[$];

  sync_counter_if #(.WIDTH(WIDTH)) bus ();

  sync_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs for the coming edge; expected count is the value before that edge.
  task automatic step(input logic r, input logic e,
                      input logic [WIDTH-1:0] c, input logic t);
    exp_t x;
    reset      = r;
    bus.enable = e;
    x.count    = c;
    x.tc       = t;
    x.idx      = vec;
    sb_q.push_back(x);
    vec++;
    @(negedge clk);
  endtask

  task automatic check_one();
    exp_t x;
    x = sb_q.pop_front();
    checks++;
    if (bus.count !== x.count) begin
      errors++;
      $display("FAIL count[v%0d] actual=%0d required=%0d", x.idx, bus.count, x.count);
    end
    checks++;
    if (bus.tc !== x.tc) begin
      errors++;
      $display("FAIL tc[v%0d] actual=%b required=%b", x.idx, bus.tc, x.tc);
    end
  endtask

  // Monitor: first sample at t=1 (before the first edge), then 1 after each negedge.
  initial begin
    #1;
    if (sb_q.size() != 0) check_one();
    forever begin
      @(negedge clk);
      #1;
      if (sb_q.size() != 0) check_one();
    end
  end

  initial begin
    bus.enable = 1'b0;
    // count up without any reset
    step(0, 1, 3'd0, 0);
    step(0, 1, 3'd1, 0);
    step(0, 1, 3'd2, 0);
    // hold
    step(0, 0, 3'd3, 0);
    step(0, 0, 3'd3, 0);
    step(0, 0, 3'd3, 0);
    // count through wrap
    step(0, 1, 3'd3, 0);
    step(0, 1, 3'd4, 0);
    step(0, 1, 3'd5, 0);
    step(0, 1, 3'd6, 0);
    step(0, 1, 3'd7, 1);
    step(0, 1, 3'd0, 0);
    step(0, 1, 3'd1, 0);
    // reset mid-count with enable high
    step(1, 1, 3'd2, 0);
    step(0, 1, 3'd0, 0);
    step(0, 1, 3'd1, 0);
    step(0, 1, 3'd2, 0);
    step(0, 1, 3'd3, 0);
    step(0, 1, 3'd4, 0);
    // reset and enable together at count 5
    step(1, 1, 3'd5, 0);
    step(0, 1, 3'd0, 0);
    step(0, 1, 3'd1, 0);
    step(0, 1, 3'd2, 0);
    step(0, 1, 3'd3, 0);
    step(0, 1, 3'd4, 0);
    step(0, 1, 3'd5, 0);
    step(0, 1, 3'd6, 0);
    // at max: tc low without enable, low while reset
    step(0, 0, 3'd7, 0);
    step(1, 1, 3'd7, 0);
    step(0, 0, 3'd0, 0);
    step(0, 0, 3'd0, 0);

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
